// File: rtl/ibex_cheri_cap_mem_seq.sv
// ibex_cheri_cap_mem_seq: sequences LSU accesses onto the 32-bit tagged data bus,
// splitting 64-bit capability accesses into two word beats.
//   lsu_*    : LSU request side (held until lsu_gnt_o), completion pulse lsu_rvalid_o with results
//   chk_exc_i: combinational authority-check result, latched at acceptance
//   data_*   : single-outstanding word bus (req/gnt, then rvalid/err/rdata/rtag)
//   busy_o   : an access is in flight
module ibex_cheri_cap_mem_seq #(
    parameter bit          HiFirst       = 1'b0,
    parameter bit          MergeTag      = 1'b1,
    parameter int unsigned CheriExcWidth = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     lsu_req_i,
    input  logic                     lsu_we_i,
    input  logic                     lsu_cap_i,
    input  logic [31:0]              lsu_addr_i,
    input  logic [3:0]               lsu_be_i,
    input  logic [63:0]              lsu_wdata_i,
    input  logic                     lsu_wtag_i,
    input  logic [CheriExcWidth-1:0] chk_exc_i,
    output logic                     lsu_gnt_o,
    output logic                     lsu_rvalid_o,
    output logic [63:0]              lsu_rdata_o,
    output logic                     lsu_rtag_o,
    output logic                     lsu_err_o,
    output logic                     lsu_misaligned_o,
    output logic [CheriExcWidth-1:0] lsu_cheri_exc_o,
    output logic                     busy_o,
    output logic                     data_req_o,
    input  logic                     data_gnt_i,
    input  logic                     data_rvalid_i,
    input  logic                     data_err_i,
    output logic [31:0]              data_addr_o,
    output logic                     data_we_o,
    output logic [3:0]               data_be_o,
    output logic [31:0]              data_wdata_o,
    output logic                     data_wtag_o,
    input  logic [31:0]              data_rdata_i,
    input  logic                     data_rtag_i
);
    typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE} state_e;

    state_e                   state_q;
    logic                     cap_q, first_tag_q;
    logic [31:0]              addr_q;
    logic [63:0]              wdata_q;
    logic                     data_req_q, data_we_q, data_wtag_q;
    logic [31:0]              data_addr_q, data_wdata_q;
    logic [3:0]               data_be_q;
    logic                     rvalid_q, rtag_q, err_q, mis_q;
    logic [63:0]              rdata_q;
    logic [CheriExcWidth-1:0] exc_q;

    logic        mis_d, fault_d, tag_b_d;
    logic [31:0] addr_a_d, addr_b_d, wdata_a_d, wdata_b_d;

    assign mis_d     = lsu_cap_i & |lsu_addr_i[2:0];
    assign fault_d   = |chk_exc_i | mis_d;
    // First beat: word-aligned for non-cap, otherwise the low or high word by HiFirst.
    assign addr_a_d  = !lsu_cap_i ? {lsu_addr_i[31:2], 2'b00} : HiFirst ? lsu_addr_i + 32'd4 : lsu_addr_i;
    assign wdata_a_d = (lsu_cap_i & HiFirst) ? lsu_wdata_i[63:32] : lsu_wdata_i[31:0];
    assign addr_b_d  = HiFirst ? addr_q : addr_q + 32'd4;
    assign wdata_b_d = HiFirst ? wdata_q[31:0] : wdata_q[63:32];
    // Without merging, the tag comes from the addr+4 beat, which is the first beat when HiFirst.
    assign tag_b_d   = MergeTag ? first_tag_q & data_rtag_i : HiFirst ? first_tag_q : data_rtag_i;

    assign lsu_gnt_o        = (state_q == IDLE) & lsu_req_i & ~rst_i;
    assign busy_o           = state_q != IDLE;
    assign lsu_rvalid_o     = rvalid_q;
    assign lsu_rdata_o      = rdata_q;
    assign lsu_rtag_o       = rtag_q;
    assign lsu_err_o        = err_q;
    assign lsu_misaligned_o = mis_q;
    assign lsu_cheri_exc_o  = exc_q;
    assign data_req_o       = data_req_q;
    assign data_addr_o      = data_addr_q;
    assign data_we_o        = data_we_q;
    assign data_be_o        = data_be_q;
    assign data_wdata_o     = data_wdata_q;
    assign data_wtag_o      = data_wtag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cap_q        <= 1'b0;
            first_tag_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_wtag_q  <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_be_q    <= '0;
            rvalid_q     <= 1'b0;
            rtag_q       <= 1'b0;
            err_q        <= 1'b0;
            mis_q        <= 1'b0;
            rdata_q      <= '0;
            exc_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (lsu_gnt_o) begin
                    cap_q        <= lsu_cap_i;
                    addr_q       <= lsu_addr_i;
                    wdata_q      <= lsu_wdata_i;
                    exc_q        <= chk_exc_i;
                    mis_q        <= mis_d;
                    err_q        <= 1'b0;
                    rdata_q      <= '0;
                    rtag_q       <= 1'b0;
                    data_req_q   <= ~fault_d;
                    data_addr_q  <= addr_a_d;
                    data_we_q    <= lsu_we_i;
                    data_be_q    <= lsu_cap_i ? 4'hF : lsu_be_i;
                    data_wdata_q <= wdata_a_d;
                    data_wtag_q  <= lsu_we_i & lsu_cap_i & lsu_wtag_i;
                    rvalid_q     <= fault_d;
                    state_q      <= fault_d ? DONE : REQ_A;
                end
                REQ_A, REQ_B: if (data_gnt_i) begin
                    data_req_q <= 1'b0;
                    state_q    <= (state_q == REQ_A) ? WAIT_A : WAIT_B;
                end
                WAIT_A: if (data_rvalid_i) begin
                    err_q       <= err_q | data_err_i;
                    first_tag_q <= data_rtag_i;
                    if (!data_err_i) begin
                        if (cap_q && HiFirst) rdata_q[63:32] <= data_rdata_i;
                        else rdata_q[31:0] <= data_rdata_i;
                    end
                    if (data_err_i || !cap_q) begin
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        data_req_q   <= 1'b1;
                        data_addr_q  <= addr_b_d;
                        data_wdata_q <= wdata_b_d;
                        state_q      <= REQ_B;
                    end
                end
                WAIT_B: if (data_rvalid_i) begin
                    err_q <= err_q | data_err_i;
                    if (data_err_i) rdata_q <= '0;
                    else if (HiFirst) rdata_q[31:0] <= data_rdata_i;
                    else rdata_q[63:32] <= data_rdata_i;
                    rtag_q   <= ~data_err_i & tag_b_d;
                    rvalid_q <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_cheri_cap_mem_seq.sv
// tb_ibex_cheri_cap_mem_seq: directed bench for ibex_cheri_cap_mem_seq.
//   dut0: HiFirst=0, MergeTag=1; dut1: HiFirst=1, MergeTag=0; both share the LSU inputs,
//   each has its own address-keyed memory responder with programmable gnt stall.
module tb_ibex_cheri_cap_mem_seq;
    localparam int EW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          lsu_req, lsu_we, lsu_cap, lsu_wtag;
    logic [31:0]   lsu_addr;
    logic [3:0]    lsu_be;
    logic [63:0]   lsu_wdata;
    logic [EW-1:0] chk_exc;

    logic          gnt[2], rvalid[2], rtag[2], err[2], mis[2], busy[2];
    logic [63:0]   rdata[2];
    logic [EW-1:0] exc[2];

    logic        d_req[2], d_we[2], d_wtag[2];
    logic [31:0] d_addr[2], d_wdata[2];
    logic [3:0]  d_be[2];
    logic        d_gnt[2]    = '{1'b0, 1'b0};
    logic        d_rvalid[2] = '{1'b0, 1'b0};
    logic        d_err[2]    = '{1'b0, 1'b0};
    logic        d_rtag[2]   = '{1'b0, 1'b0};
    logic [31:0] d_rdata[2]  = '{32'h0, 32'h0};

    ibex_cheri_cap_mem_seq #(.HiFirst(1'b0), .MergeTag(1'b1), .CheriExcWidth(EW)) dut0 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_cap_i(lsu_cap),
        .lsu_addr_i(lsu_addr), .lsu_be_i(lsu_be), .lsu_wdata_i(lsu_wdata), .lsu_wtag_i(lsu_wtag),
        .chk_exc_i(chk_exc), .lsu_gnt_o(gnt[0]), .lsu_rvalid_o(rvalid[0]), .lsu_rdata_o(rdata[0]),
        .lsu_rtag_o(rtag[0]), .lsu_err_o(err[0]), .lsu_misaligned_o(mis[0]), .lsu_cheri_exc_o(exc[0]),
        .busy_o(busy[0]), .data_req_o(d_req[0]), .data_gnt_i(d_gnt[0]), .data_rvalid_i(d_rvalid[0]),
        .data_err_i(d_err[0]), .data_addr_o(d_addr[0]), .data_we_o(d_we[0]), .data_be_o(d_be[0]),
        .data_wdata_o(d_wdata[0]), .data_wtag_o(d_wtag[0]), .data_rdata_i(d_rdata[0]), .data_rtag_i(d_rtag[0])
    );

    ibex_cheri_cap_mem_seq #(.HiFirst(1'b1), .MergeTag(1'b0), .CheriExcWidth(EW)) dut1 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_cap_i(lsu_cap),
        .lsu_addr_i(lsu_addr), .lsu_be_i(lsu_be), .lsu_wdata_i(lsu_wdata), .lsu_wtag_i(lsu_wtag),
        .chk_exc_i(chk_exc), .lsu_gnt_o(gnt[1]), .lsu_rvalid_o(rvalid[1]), .lsu_rdata_o(rdata[1]),
        .lsu_rtag_o(rtag[1]), .lsu_err_o(err[1]), .lsu_misaligned_o(mis[1]), .lsu_cheri_exc_o(exc[1]),
        .busy_o(busy[1]), .data_req_o(d_req[1]), .data_gnt_i(d_gnt[1]), .data_rvalid_i(d_rvalid[1]),
        .data_err_i(d_err[1]), .data_addr_o(d_addr[1]), .data_we_o(d_we[1]), .data_be_o(d_be[1]),
        .data_wdata_o(d_wdata[1]), .data_wtag_o(d_wtag[1]), .data_rdata_i(d_rdata[1]), .data_rtag_i(d_rtag[1])
    );

    logic [31:0] mem_d [logic [31:0]];
    logic        mem_t [logic [31:0]];
    int          gnt_delay = 0;
    logic        err_inj = 1'b0;
    logic        hold_rv = 1'b0;

    int          req_cyc[2]  = '{0, 0};
    int          unstable[2] = '{0, 0};
    int          wait_cnt[2] = '{0, 0};
    int          log_n[2]    = '{0, 0};
    logic        pend[2]     = '{1'b0, 1'b0};
    logic [31:0] pend_addr[2];
    logic [69:0] held[2];
    logic [31:0] lg_addr[2][64], lg_wdata[2][64];
    logic [3:0]  lg_be[2][64];
    logic        lg_we[2][64], lg_wtag[2][64];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_d.exists(a) ? mem_d[a] : 32'hDEAD0000;
    endfunction

    function automatic logic tag_rd(input logic [31:0] a);
        return mem_t.exists(a) ? mem_t[a] : 1'b0;
    endfunction

    // Bus responder: gnt after gnt_delay request cycles, rvalid the cycle after gnt.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            d_gnt[g]    = 1'b0;
            d_rvalid[g] = 1'b0;
            d_err[g]    = 1'b0;
            if (pend[g] && !hold_rv) begin
                d_rvalid[g] = 1'b1;
                d_err[g]    = err_inj;
                d_rdata[g]  = mem_rd(pend_addr[g]);
                d_rtag[g]   = tag_rd(pend_addr[g]);
                pend[g]     = 1'b0;
            end
            if (d_req[g]) begin
                req_cyc[g]++;
                if (wait_cnt[g] == 0) held[g] = {d_addr[g], d_we[g], d_be[g], d_wdata[g], d_wtag[g]};
                else if (held[g] != {d_addr[g], d_we[g], d_be[g], d_wdata[g], d_wtag[g]}) unstable[g]++;
                if (wait_cnt[g] >= gnt_delay) begin
                    d_gnt[g]     = 1'b1;
                    pend[g]      = 1'b1;
                    pend_addr[g] = d_addr[g];
                    lg_addr[g][log_n[g] % 64]  = d_addr[g];
                    lg_wdata[g][log_n[g] % 64] = d_wdata[g];
                    lg_be[g][log_n[g] % 64]    = d_be[g];
                    lg_we[g][log_n[g] % 64]    = d_we[g];
                    lg_wtag[g][log_n[g] % 64]  = d_wtag[g];
                    log_n[g]++;
                    wait_cnt[g] = 0;
                end else begin
                    wait_cnt[g]++;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    int            lat;
    logic [63:0]   r_data[2];
    logic          r_tag[2], r_err[2], r_mis[2];
    logic [EW-1:0] r_exc[2];

    // One complete access; lat counts cycles from acceptance to lsu_rvalid_o.
    task automatic access(input logic we, input logic cap, input logic [31:0] addr, input logic [3:0] be,
                          input logic [63:0] wdata, input logic wtag, input logic [EW-1:0] exc_in);
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_cap = cap; lsu_addr = addr; lsu_be = be;
        lsu_wdata = wdata; lsu_wtag = wtag; chk_exc = exc_in;
        #1;
        chk("gnt_idle", {63'd0, gnt[0]}, 64'd1);
        @(negedge clk);
        lsu_req = 1'b0;
        lat = 1;
        while (!rvalid[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rvalid_dut1", {63'd0, rvalid[1]}, 64'd1);
        for (int g = 0; g < 2; g++) begin
            r_data[g] = rdata[g]; r_tag[g] = rtag[g]; r_err[g] = err[g];
            r_mis[g] = mis[g]; r_exc[g] = exc[g];
        end
    endtask

    int n0, n1, rq0, us0, gnts, rvs, bad, stray;

    initial begin
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_cap = 1'b0; lsu_addr = '0; lsu_be = '0;
        lsu_wdata = '0; lsu_wtag = 1'b0; chk_exc = '0;
        mem_d[32'h1000] = 32'hAAAA0000; mem_t[32'h1000] = 1'b1;
        mem_d[32'h1004] = 32'hBBBB1111; mem_t[32'h1004] = 1'b1;
        mem_d[32'h2000] = 32'h0; mem_d[32'h2004] = 32'h0;
        mem_d[32'h3000] = 32'hCAFEBABE; mem_t[32'h3000] = 1'b1;
        mem_d[32'h4000] = 32'h0;
        repeat (3) @(negedge clk);
        lsu_req = 1'b1;
        #1;
        chk("rst_gnt", {63'd0, gnt[0]}, 64'd0);
        chk("rst_busy", {63'd0, busy[0]}, 64'd0);
        chk("rst_dreq", {63'd0, d_req[0]}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid[0]}, 64'd0);
        chk("rst_rdata", rdata[0], 64'd0);
        lsu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Capability load, both tags set
        n0 = log_n[0]; n1 = log_n[1];
        access(1'b0, 1'b1, 32'h1000, 4'h0, 64'h0, 1'b0, '0);
        chk("t1_lat", 64'(lat), 64'd5);
        chk("t1_rdata0", r_data[0], 64'hBBBB1111AAAA0000);
        chk("t1_rtag0", {63'd0, r_tag[0]}, 64'd1);
        chk("t1_rdata1", r_data[1], 64'hBBBB1111AAAA0000);
        chk("t1_rtag1", {63'd0, r_tag[1]}, 64'd1);
        chk("t1_beats0", 64'(log_n[0] - n0), 64'd2);
        chk("t1_addrA0", {32'd0, lg_addr[0][n0 % 64]}, 64'h1000);
        chk("t1_addrB0", {32'd0, lg_addr[0][(n0 + 1) % 64]}, 64'h1004);
        chk("t1_addrA1", {32'd0, lg_addr[1][n1 % 64]}, 64'h1004);
        chk("t1_addrB1", {32'd0, lg_addr[1][(n1 + 1) % 64]}, 64'h1000);

        // Tag merging: high word tag clear, then low word tag clear
        mem_t[32'h1004] = 1'b0;
        access(1'b0, 1'b1, 32'h1000, 4'h0, 64'h0, 1'b0, '0);
        chk("t2_rtag0_hi0", {63'd0, r_tag[0]}, 64'd0);
        chk("t2_rtag1_hi0", {63'd0, r_tag[1]}, 64'd0);
        mem_t[32'h1000] = 1'b0; mem_t[32'h1004] = 1'b1;
        access(1'b0, 1'b1, 32'h1000, 4'h0, 64'h0, 1'b0, '0);
        chk("t2_rtag0_lo0", {63'd0, r_tag[0]}, 64'd0);
        chk("t2_rtag1_lo0", {63'd0, r_tag[1]}, 64'd1);
        mem_t[32'h1000] = 1'b1;

        // Capability store
        n0 = log_n[0]; n1 = log_n[1];
        access(1'b1, 1'b1, 32'h2000, 4'h0, 64'h01234567_89ABCDEF, 1'b1, '0);
        chk("t3_lat", 64'(lat), 64'd5);
        chk("t3_beats", 64'(log_n[0] - n0), 64'd2);
        chk("t3_addrA", {32'd0, lg_addr[0][n0 % 64]}, 64'h2000);
        chk("t3_wdA", {32'd0, lg_wdata[0][n0 % 64]}, 64'h89ABCDEF);
        chk("t3_beA", {60'd0, lg_be[0][n0 % 64]}, 64'hF);
        chk("t3_weA", {63'd0, lg_we[0][n0 % 64]}, 64'd1);
        chk("t3_wtagA", {63'd0, lg_wtag[0][n0 % 64]}, 64'd1);
        chk("t3_addrB", {32'd0, lg_addr[0][(n0 + 1) % 64]}, 64'h2004);
        chk("t3_wdB", {32'd0, lg_wdata[0][(n0 + 1) % 64]}, 64'h01234567);
        chk("t3_beB", {60'd0, lg_be[0][(n0 + 1) % 64]}, 64'hF);
        chk("t3_wtagB", {63'd0, lg_wtag[0][(n0 + 1) % 64]}, 64'd1);
        chk("t3_addrA1", {32'd0, lg_addr[1][n1 % 64]}, 64'h2004);
        chk("t3_wdA1", {32'd0, lg_wdata[1][n1 % 64]}, 64'h01234567);

        // Same store with a tag violation from the checker
        rq0 = req_cyc[0];
        access(1'b1, 1'b1, 32'h2000, 4'h0, 64'h01234567_89ABCDEF, 1'b1, 5'b00010);
        chk("t3x_lat", 64'(lat), 64'd1);
        chk("t3x_exc", {59'd0, r_exc[0]}, 64'h2);
        chk("t3x_noreq", 64'(req_cyc[0] - rq0), 64'd0);
        chk("t3x_rtag", {63'd0, r_tag[0]}, 64'd0);

        // Misaligned capability
        rq0 = req_cyc[0];
        access(1'b0, 1'b1, 32'h2004, 4'h0, 64'h0, 1'b0, '0);
        chk("t4_lat", 64'(lat), 64'd1);
        chk("t4_mis", {63'd0, r_mis[0]}, 64'd1);
        chk("t4_noreq", 64'(req_cyc[0] - rq0), 64'd0);
        chk("t4_rdata", r_data[0], 64'd0);

        // Word load with bus error, then capability load erroring on first beat
        err_inj = 1'b1;
        n0 = log_n[0];
        access(1'b0, 1'b0, 32'h3002, 4'hC, 64'h0, 1'b0, '0);
        chk("t4e_lat", 64'(lat), 64'd3);
        chk("t4e_err", {63'd0, r_err[0]}, 64'd1);
        chk("t4e_rdata", r_data[0], 64'd0);
        chk("t4e_beats", 64'(log_n[0] - n0), 64'd1);
        chk("t4e_addr", {32'd0, lg_addr[0][n0 % 64]}, 64'h3000);
        n0 = log_n[0];
        access(1'b0, 1'b1, 32'h1000, 4'h0, 64'h0, 1'b0, '0);
        chk("t4c_lat", 64'(lat), 64'd3);
        chk("t4c_err", {63'd0, r_err[0]}, 64'd1);
        chk("t4c_beats", 64'(log_n[0] - n0), 64'd1);
        chk("t4c_rdata", r_data[0], 64'd0);
        err_inj = 1'b0;

        // Plain word load: upper half and tag forced to zero
        n0 = log_n[0];
        access(1'b0, 1'b0, 32'h3002, 4'hC, 64'h0, 1'b0, '0);
        chk("t4w_lat", 64'(lat), 64'd3);
        chk("t4w_rdata", r_data[0], 64'h00000000CAFEBABE);
        chk("t4w_rtag", {63'd0, r_tag[0]}, 64'd0);
        chk("t4w_err", {63'd0, r_err[0]}, 64'd0);
        chk("t4w_be", {60'd0, lg_be[0][n0 % 64]}, 64'hC);

        // Stalled grant on a word store
        gnt_delay = 3;
        n0 = log_n[0]; rq0 = req_cyc[0]; us0 = unstable[0];
        access(1'b1, 1'b0, 32'h4002, 4'h3, 64'hFFFFFFFF_5555AAAA, 1'b1, '0);
        gnt_delay = 0;
        chk("t5_lat", 64'(lat), 64'd6);
        chk("t5_reqcyc", 64'(req_cyc[0] - rq0), 64'd4);
        chk("t5_stable", 64'(unstable[0] - us0), 64'd0);
        chk("t5_addr", {32'd0, lg_addr[0][n0 % 64]}, 64'h4000);
        chk("t5_wdata", {32'd0, lg_wdata[0][n0 % 64]}, 64'h5555AAAA);
        chk("t5_be", {60'd0, lg_be[0][n0 % 64]}, 64'h3);
        chk("t5_wtag", {63'd0, lg_wtag[0][n0 % 64]}, 64'd0);

        // Reset while waiting for the second beat, stray rvalid afterwards
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_cap = 1'b1; lsu_addr = 32'h1000; chk_exc = '0;
        #1;
        chk("t5r_gnt", {63'd0, gnt[0]}, 64'd1);
        @(negedge clk);
        lsu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5r_reqB", {63'd0, d_req[0]}, 64'd1);
        hold_rv = 1'b1;
        @(negedge clk);
        chk("t5r_waitB", {62'd0, busy[0], d_req[0]}, 64'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5r_idle", {61'd0, busy[0], d_req[0], rvalid[0]}, 64'd0);
        hold_rv = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            stray += int'(rvalid[0] | busy[0]);
        end
        chk("t5r_stray", 64'(stray), 64'd0);
        access(1'b0, 1'b0, 32'h3000, 4'hF, 64'h0, 1'b0, '0);
        chk("t5r_next", r_data[0], 64'h00000000CAFEBABE);
        chk("t5r_nlat", 64'(lat), 64'd3);

        // Back-to-back requests held high
        rq0 = req_cyc[0];
        gnts = 0; rvs = 0; bad = 0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_cap = 1'b0; lsu_addr = 32'h3000; lsu_be = 4'hF;
        for (int i = 0; i < 12; i++) begin
            #1;
            gnts += int'(gnt[0]);
            rvs  += int'(rvalid[0]);
            bad  += int'(gnt[0] & busy[0]);
            @(negedge clk);
        end
        lsu_req = 1'b0;
        chk("t6_gnts", 64'(gnts), 64'd3);
        chk("t6_rvalids", 64'(rvs), 64'd3);
        chk("t6_gnt_busy", 64'(bad), 64'd0);
        chk("t6_reqcyc", 64'(req_cyc[0] - rq0), 64'd3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
